// File: rtl/fifo_line_reader_if.sv
// Word-FIFO reader / line handshake bundle for fifo_line_reader.
// The master modport is the reader block; the slave modport is its environment.
interface fifo_line_reader_if #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4
);
  logic                                 flush_en;
  logic                                 fifo_empty;
  logic                                 fifo_dequeue_en;
  logic [DATA_WIDTH-1:0]                fifo_value;
  logic                                 line_valid;
  logic                                 line_ready;
  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] line_data;
  logic [WORDS_PER_LINE-1:0]            line_word_mask;
  logic                                 busy;

  modport master (
    input  flush_en, fifo_empty, fifo_value, line_ready,
    output fifo_dequeue_en, line_valid, line_data, line_word_mask, busy
  );

  modport slave (
    output flush_en, fifo_empty, fifo_value, line_ready,
    input  fifo_dequeue_en, line_valid, line_data, line_word_mask, busy
  );
endinterface

// File: rtl/fifo_line_reader.sv
// Pops words from a show-ahead FIFO, packs them into lines and offers each line on valid/ready.
// Optional LINE_TIMEOUT_EN: emit a partial line after TIMEOUT_CYCLES idle cycles.
module fifo_line_reader #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  fifo_line_reader_if.master  bus
);
  localparam int unsigned IDX_W  = $clog2(WORDS_PER_LINE);
  localparam int unsigned LINE_W = DATA_WIDTH * WORDS_PER_LINE;

  typedef enum logic {FILL, HOLD} state_e;

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          idx_q, idx_d;
  logic [LINE_W-1:0]         data_q, data_d;
  logic [WORDS_PER_LINE-1:0] mask_q, mask_d;
  logic                      deq_c;
  logic                      timeout_c;

  // Pop is combinational so the show-ahead head word is taken in the same cycle.
  always_comb deq_c = (state_q == FILL) && !bus.fifo_empty && !bus.flush_en;

`ifdef LINE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Idle counter: only runs while a partial line sits in FILL without new words.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_c = 1'b0;
    if (bus.flush_en || deq_c || state_q == HOLD || idx_q == '0) begin
      cnt_d = '0;
    end else begin
      cnt_d     = cnt_q + 1'b1;
      timeout_c = (cnt_d == CNT_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  always_comb timeout_c = 1'b0;
`endif

  // Next-state logic; flush overrides both dequeue and accept.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    if (bus.flush_en) begin
      state_d = FILL;
      idx_d   = '0;
      mask_d  = '0;
    end else begin
      case (state_q)
        FILL: begin
          if (deq_c) begin
            data_d[int'(idx_q)*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_value;
            mask_d[idx_q] = 1'b1;
            idx_d         = idx_q + 1'b1;
            if (idx_q == IDX_W'(WORDS_PER_LINE - 1)) state_d = HOLD;
          end else if (timeout_c) begin
            state_d = HOLD;
          end
        end
        HOLD: begin
          if (bus.line_ready) begin
            state_d = FILL;
            idx_d   = '0;
            mask_d  = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      idx_q   <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  assign bus.fifo_dequeue_en = deq_c;
  assign bus.line_valid      = (state_q == HOLD);
  assign bus.line_data       = data_q;
  assign bus.line_word_mask  = mask_q;
  assign bus.busy            = (state_q == HOLD) || (idx_q != '0);

  // Protocol checks: never pop an empty FIFO; a stalled line must not change.
  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset)
    !(bus.fifo_dequeue_en && bus.fifo_empty))
    else $error("dequeue while fifo_empty");

  a_line_stable: assert property (@(posedge clk) disable iff (reset)
    (bus.line_valid && !bus.line_ready && !bus.flush_en) |=>
      ($stable(bus.line_data) && $stable(bus.line_word_mask)))
    else $error("line changed while stalled");
endmodule

// File: tb/tb_fifo_line_reader.sv
// Directed bench for fifo_line_reader: a queue models the show-ahead source FIFO.
module tb_fifo_line_reader;
  localparam int unsigned DW = 32;
  localparam int unsigned WPL = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec = 0;
  int   fails = 0;
  logic starve = 1'b0;
  logic [DW-1:0] q[$];

  fifo_line_reader_if #(.DATA_WIDTH(DW), .WORDS_PER_LINE(WPL)) bus ();

  fifo_line_reader #(.DATA_WIDTH(DW), .WORDS_PER_LINE(WPL), .TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: present FIFO head, sample pop mid-cycle, pop the model on the edge.
  task automatic tick(output logic d);
    bus.fifo_empty = (q.size() == 0) || starve;
    bus.fifo_value = (q.size() != 0) ? q[0] : '0;
    #4;
    d = bus.fifo_dequeue_en;
    @(posedge clk);
    if (d && q.size() != 0) void'(q.pop_front());
    #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    q.push_back(w);
  endtask

  initial begin
    logic d;
    int   n, bad;
    bus.flush_en   = 1'b0;
    bus.line_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_value = '0;
    #12 reset = 1'b0;
    @(posedge clk); #1;

    chk("rst_valid", 128'(bus.line_valid), 128'd0);
    chk("rst_mask",  128'(bus.line_word_mask), 128'd0);
    chk("rst_busy",  128'(bus.busy), 128'd0);
    chk("rst_deq",   128'(bus.fifo_dequeue_en), 128'd0);
    chk("rst_data",  128'(bus.line_data), 128'd0);

    // Basic line with ready high
    bus.line_ready = 1'b1;
    push(32'h11); push(32'h22); push(32'h33); push(32'h44);
    for (int i = 0; i < 4; i++) begin
      tick(d);
      chk("t1_deq", 128'(d), 128'd1);
    end
    chk("t1_valid", 128'(bus.line_valid), 128'd1);
    chk("t1_data", 128'(bus.line_data), {32'h44, 32'h33, 32'h22, 32'h11});
    chk("t1_mask", 128'(bus.line_word_mask), 128'hf);
    tick(d);
    chk("t1_acc_valid", 128'(bus.line_valid), 128'd0);
    chk("t1_acc_busy", 128'(bus.busy), 128'd0);

    // Back-pressure: line held for 10 cycles, then second line
    bus.line_ready = 1'b0;
    for (int i = 1; i <= 8; i++) push(DW'(i * 32'h11));
    for (int i = 0; i < 4; i++) tick(d);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick(d);
      if (d) n++;
    end
    chk("t2_hold_deq", 128'(n), 128'd0);
    chk("t2_hold_valid", 128'(bus.line_valid), 128'd1);
    chk("t2_hold_data", 128'(bus.line_data), {32'h44, 32'h33, 32'h22, 32'h11});
    bus.line_ready = 1'b1;
    tick(d);
    chk("t2_acc_deq", 128'(d), 128'd0);
    chk("t2_acc_valid", 128'(bus.line_valid), 128'd0);
    n = 0;
    for (int i = 0; i < 4; i++) begin
      tick(d);
      if (d) n++;
    end
    chk("t2_pops2", 128'(n), 128'd4);
    chk("t2_data2", 128'(bus.line_data), {32'h88, 32'h77, 32'h66, 32'h55});
    tick(d);

    // Source empty every other cycle
    push(32'hA1); push(32'hA2); push(32'hA3); push(32'hA4);
    n = 0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      starve = (i % 2 == 0);
      tick(d);
      if (d) n++;
      if (d && starve) bad++;
    end
    starve = 1'b0;
    chk("t3_pops", 128'(n), 128'd4);
    chk("t3_pop_empty", 128'(bad), 128'd0);
    chk("t3_valid", 128'(bus.line_valid), 128'd1);
    chk("t3_data", 128'(bus.line_data), {32'hA4, 32'hA3, 32'hA2, 32'hA1});
    tick(d);

    // Flush a partial line, then flush a held line while ready is high
    bus.line_ready = 1'b0;
    push(32'hB1); push(32'hB2);
    tick(d); tick(d);
    chk("t4_busy_part", 128'(bus.busy), 128'd1);
    push(32'hC1); push(32'hC2); push(32'hC3); push(32'hC4);
    bus.flush_en = 1'b1;
    tick(d);
    bus.flush_en = 1'b0;
    chk("t4_flush_deq", 128'(d), 128'd0);
    chk("t4_flush_busy", 128'(bus.busy), 128'd0);
    chk("t4_flush_mask", 128'(bus.line_word_mask), 128'd0);
    for (int i = 0; i < 4; i++) tick(d);
    chk("t4_valid", 128'(bus.line_valid), 128'd1);
    chk("t4_data", 128'(bus.line_data), {32'hC4, 32'hC3, 32'hC2, 32'hC1});
    chk("t4_mask", 128'(bus.line_word_mask), 128'hf);
    bus.line_ready = 1'b1;
    bus.flush_en = 1'b1;
    tick(d);
    bus.flush_en = 1'b0;
    bus.line_ready = 1'b0;
    chk("t4_hflush_valid", 128'(bus.line_valid), 128'd0);
    chk("t4_hflush_busy", 128'(bus.busy), 128'd0);

    // Asynchronous reset in the middle of HOLD
    push(32'hD1); push(32'hD2); push(32'hD3); push(32'hD4);
    for (int i = 0; i < 4; i++) tick(d);
    chk("t5_pre_valid", 128'(bus.line_valid), 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_rst_valid", 128'(bus.line_valid), 128'd0);
    chk("t5_rst_mask", 128'(bus.line_word_mask), 128'd0);
    chk("t5_rst_busy", 128'(bus.busy), 128'd0);
    reset = 1'b0;

    // Partial line starved of words
    push(32'hE1); push(32'hE2); push(32'hE3);
    for (int i = 0; i < 3; i++) tick(d);
    for (int i = 0; i < 15; i++) tick(d);
    chk("t6_valid_15", 128'(bus.line_valid), 128'd0);
    tick(d);
`ifdef LINE_TIMEOUT_EN
    chk("t6_valid_16", 128'(bus.line_valid), 128'd1);
    chk("t6_mask", 128'(bus.line_word_mask), 128'h7);
    chk("t6_data", 128'(bus.line_data), {32'h0, 32'hE3, 32'hE2, 32'hE1});
    bus.line_ready = 1'b1;
    tick(d);
    chk("t6_acc_busy", 128'(bus.busy), 128'd0);
`else
    for (int i = 0; i < 20; i++) tick(d);
    chk("t6_no_timeout", 128'(bus.line_valid), 128'd0);
    chk("t6_busy", 128'(bus.busy), 128'd1);
    chk("t6_mask", 128'(bus.line_word_mask), 128'h7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end
endmodule
